seg7_scan_driver: RTL

//  Downstream display stage of the button/counter top level. It takes the 16-bit

---
 rtl/seg7_scan_driver.sv | 95 +++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner. The hex value and decimal points are captured
// once per scan frame, so a frame never mixes old and new digits.
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned LEAD_BLANK  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] disp_num,
   input  logic [3:0]  dp_in,
   output logic [3:0]  digit_anode,
   output logic [7:0]  segment
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

   logic [CntW-1:0] r_cnt;
   logic [1:0]      r_idx;
   logic [15:0]     r_shd_num;
   logic [3:0]      r_shd_dp;

   logic            w_tick;
   logic [3:0]      w_nib;
   logic            w_blank;
   logic [6:0]      w_hex;
   logic [3:0]      w_anode;
   logic [7:0]      w_seg;

   assign w_tick = (r_cnt == CntMax);

   always_comb begin
      w_nib   = r_shd_num[{r_idx, 2'b00} +: 4];
      w_blank = 1'b0;
      w_hex   = 7'h7F;
      // A digit is a leading zero when it and every more significant digit are zero.
      case (r_idx)
         2'd1:    w_blank = (r_shd_num[15:4] == 12'h000);
         2'd2:    w_blank = (r_shd_num[15:8] == 8'h00);
         2'd3:    w_blank = (r_shd_num[15:12] == 4'h0);
         default: w_blank = 1'b0;
      endcase
      if (LEAD_BLANK == 0) begin
         w_blank = 1'b0;
      end
      case (w_nib)
         4'h0: w_hex = 7'h40;
         4'h1: w_hex = 7'h79;
         4'h2: w_hex = 7'h24;
         4'h3: w_hex = 7'h30;
         4'h4: w_hex = 7'h19;
         4'h5: w_hex = 7'h12;
         4'h6: w_hex = 7'h02;
         4'h7: w_hex = 7'h78;
         4'h8: w_hex = 7'h00;
         4'h9: w_hex = 7'h10;
         4'hA: w_hex = 7'h08;
         4'hB: w_hex = 7'h03;
         4'hC: w_hex = 7'h46;
         4'hD: w_hex = 7'h21;
         4'hE: w_hex = 7'h06;
         default: w_hex = 7'h0E;
      endcase
      w_anode = ~(4'b0001 << r_idx);
      w_seg   = {~r_shd_dp[r_idx], w_hex};
      if (w_blank) begin
         w_anode = 4'b1111;
         w_seg   = 8'hFF;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_idx       <= 2'd0;
         r_shd_num   <= 16'h0000;
         r_shd_dp    <= 4'h0;
         digit_anode <= 4'b1111;
         segment     <= 8'hFF;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + CntW'(1);
         if (w_tick) begin
            r_idx <= r_idx + 2'd1;
            // Capture only at the frame boundary so digits 0..3 of one frame agree.
            if (r_idx == 2'd3) begin
               r_shd_num <= disp_num;
               r_shd_dp  <= dp_in;
            end
         end
         digit_anode <= w_anode;
         segment     <= w_seg;
      end
   end

endmodule
